csa_stream_accumulator: RTL and testbench

//  Streaming multi-operand accumulator. Each beat delivers three WIDTH-bit operands plus a carry-in.
//  A running total is held in redundant carry-save form (sum + carry vectors), so no carry ripples per beat.
//  On the beat flagged last, one carry-propagate add resolves the total, which is then offered on a valid/ready output.

---
 rtl/csa_stream_accumulator_pkg.sv | 27 ++
 rtl/csa_stream_accumulator_if.sv | 35 +++
 rtl/csa_stream_accumulator_row.sv | 20 ++
 rtl/csa_stream_accumulator.sv | 117 +++++++++++
 tb/tb_csa_stream_accumulator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and elaboration-time helpers for the carry-save stream accumulator.
// Contents:
//   state_t    - accumulator FSM state encoding
//   max_beats  - largest beat count whose worst-case total still fits in acc_w bits
//   clog2      - ceiling log2 for sizing counters
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Worst-case beat contributes 3*(2^width-1) + 1 (the carry-in).
  function automatic int max_beats(input int width, input int acc_w);
    return ((1 << acc_w) - 1) / (3 * ((1 << width) - 1) + 1);
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Beat input and result output bundle of the carry-save stream accumulator.
// Ports (master = producer/consumer side, slave = accumulator):
//   in_valid/in_ready, in_a/in_b/in_c (WIDTH), in_cin, in_last  - beat channel
//   out_valid/out_ready, out_sum (ACC_W), out_ovf, out_count    - result channel
interface csa_stream_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_EXTRA = 4,
  parameter int CNT_W     = 16
);
  localparam int ACC_W = WIDTH + ACC_EXTRA;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             in_cin;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_c, in_cin, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_cin, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );

endinterface

// File: rtl/csa_stream_accumulator_row.sv
// Bitwise 3:2 compressor row. The carry vector is returned unshifted; the
// caller applies the weight-2 shift.
// Ports:
//   x, y, z (W) - three addend vectors
//   s (W)       - bitwise sum x^y^z
//   c (W)       - bitwise majority (carry, same bit position)
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming three-operand accumulator with a carry-save running total.
// Each accepted beat is folded into (acc_s, acc_c) through three compressor
// rows; the beat flagged last triggers one carry-propagate add, and the
// resolved total is held on the result channel until consumed.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - csa_stream_accumulator_if.slave (beat in, result out)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no accumulation open; next beat starts from a zero total
// ACCUM   | accumulation open; beats fold into acc_s/acc_c
// RESOLVE | last beat taken; one-cycle CPA into the result register
// HOLD    | result offered; waits for out_ready
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_EXTRA = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  csa_stream_accumulator_if.slave  bus
);

  localparam int               ACC_W       = WIDTH + ACC_EXTRA;
  localparam logic [CNT_W-1:0] MAX_BEATS_C = CNT_W'(max_beats(WIDTH, ACC_W));
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  state_t state_q, state_d;
  logic   in_ready, out_valid, beat;

  logic [ACC_W-1:0] acc_s_q, acc_c_q;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;
  logic [CNT_W-1:0] out_count_q;

  logic [ACC_W-1:0] op_a, op_b, op_c, base_s, base_c;
  logic [ACC_W-1:0] s1, c1, s2, c2, s3, c3, next_c;
  logic [CNT_W-1:0] base_cnt;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = bus.in_last ? RESOLVE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = RESOLVE;
      end
      RESOLVE: state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // state_q is already IDLE during reset; keep the input closed as well
    in_ready = in_ready & rst_n;
  end

  assign beat = bus.in_valid && in_ready;

  // Carry-save datapath; the opening beat of an accumulation sees a zero total
  assign op_a     = {{ACC_EXTRA{1'b0}}, bus.in_a};
  assign op_b     = {{ACC_EXTRA{1'b0}}, bus.in_b};
  assign op_c     = {{ACC_EXTRA{1'b0}}, bus.in_c};
  assign base_s   = (state_q == IDLE) ? '0 : acc_s_q;
  assign base_c   = (state_q == IDLE) ? '0 : acc_c_q;
  assign base_cnt = (state_q == IDLE) ? '0 : count_q;

  csa_row #(.W(ACC_W)) u_row1 (.x(op_a), .y(op_b),      .z(op_c),   .s(s1), .c(c1));
  csa_row #(.W(ACC_W)) u_row2 (.x(s1),   .y(c1 << 1),   .z(base_s), .s(s2), .c(c2));
  csa_row #(.W(ACC_W)) u_row3 (.x(s2),   .y(c2 << 1),   .z(base_c), .s(s3), .c(c3));

  // Bit 0 of the shifted carry is always empty, so carry-in drops straight in
  assign next_c = (c3 << 1) | {{(ACC_W-1){1'b0}}, bus.in_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else if (beat) begin
      acc_s_q <= s3;
      acc_c_q <= next_c;
      count_q <= (base_cnt == CNT_SAT) ? base_cnt : base_cnt + 1'b1;
    end else if (state_q == RESOLVE) begin
      out_sum_q   <= acc_s_q + acc_c_q;
      out_ovf_q   <= (count_q > MAX_BEATS_C);
      out_count_q <= count_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
module tb_csa_stream_accumulator;

  localparam int WIDTH = 4;
  localparam int ACC_EXTRA = 4;
  localparam int CNT_W = 16;
  localparam int MODULUS = 256;
  localparam int MAXB = 5;

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   rdy_mode;   // 0 random, 1 forced low, 2 forced high
  int   last_wait;
  int   m_total;
  int   m_count;
  exp_t sb[$];

  csa_stream_accumulator_if #(.WIDTH(WIDTH), .ACC_EXTRA(ACC_EXTRA), .CNT_W(CNT_W)) bus ();

  csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_EXTRA(ACC_EXTRA), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer side: out_ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      bus.out_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 1) bus.out_ready = 1'b0;
      else                    bus.out_ready = 1'b1;
    end
  end

  // Monitor: every result handshake pops the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got sum %0d count %0d, expected no result", bus.out_sum, bus.out_count);
        end else begin
          e = sb.pop_front();
          chk("out_sum", int'(bus.out_sum), e.sum);
          chk("out_count", int'(bus.out_count), e.cnt);
          chk("out_ovf", int'(bus.out_ovf), e.ovf);
        end
      end
    end
  end

  // Reference model: plain integer total of everything the beats carried
  task automatic model_beat(input int a, input int b, input int c, input int cin, input int last);
    m_total += a + b + c + cin;
    if (m_count < (1 << CNT_W) - 1) m_count++;
    if (last != 0) begin
      sb.push_back('{sum: m_total % MODULUS, cnt: m_count, ovf: (m_count > MAXB) ? 1 : 0});
      m_total = 0;
      m_count = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send_beat(input int a, input int b, input int c, input int cin, input int last);
    bit ok;
    int n;
    bus.in_a     = 4'(a);
    bus.in_b     = 4'(b);
    bus.in_c     = 4'(c);
    bus.in_cin   = 1'(cin);
    bus.in_last  = 1'(last);
    bus.in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.in_valid = 1'b0;
    last_wait = n;
    if (ok) model_beat(a, b, c, cin, last);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_total = 0;
    m_count = 0;
    rdy_mode = 1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.in_cin = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    #3;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_out_ovf", int'(bus.out_ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat accumulation, then held result under backpressure
    send_beat(15, 15, 15, 1, 1);
    @(negedge clk);
    chk("resolve_in_ready", int'(bus.in_ready), 0);
    chk("resolve_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("latency_out_valid", int'(bus.out_valid), 1);
    chk("latency_out_sum", int'(bus.out_sum), 46);
    bus.in_a = 4'd1;
    bus.in_b = 4'd1;
    bus.in_c = 4'd1;
    bus.in_cin = 1'b0;
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_out_sum", int'(bus.out_sum), 46);
    end
    rdy_mode = 2;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("handshake_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("post_hold_in_ready", int'(bus.in_ready), 1);
    chk("post_hold_out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;

    // Back-to-back three-beat accumulation
    send_beat(1, 2, 3, 0, 0);
    chk("b2b_ready_beat1", last_wait, 1);
    send_beat(4, 5, 6, 1, 0);
    chk("b2b_ready_beat2", last_wait, 1);
    send_beat(7, 8, 9, 0, 1);
    chk("b2b_ready_beat3", last_wait, 1);

    // Idle gaps inside an accumulation
    send_beat(2, 0, 0, 0, 0);
    idle(3);
    send_beat(0, 3, 0, 0, 1);

    // Overflow boundary: five full beats fit, six do not
    for (int i = 0; i < 5; i++) send_beat(15, 15, 15, 1, (i == 4) ? 1 : 0);
    for (int i = 0; i < 6; i++) send_beat(15, 15, 15, 1, (i == 5) ? 1 : 0);

    // Reset in the middle of an accumulation
    send_beat(3, 3, 3, 1, 0);
    send_beat(5, 5, 5, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_out_sum", int'(bus.out_sum), 0);
    chk("midrst_out_count", int'(bus.out_count), 0);
    chk("midrst_out_ovf", int'(bus.out_ovf), 0);
    m_total = 0;
    m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(1, 1, 1, 0, 1);

    // Randomized accumulations with gaps and random backpressure
    for (int k = 0; k < 40; k++) begin
      int nb;
      nb = int'($urandom_range(1, 8));
      for (int j = 0; j < nb; j++) begin
        send_beat(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  (j == nb - 1) ? 1 : 0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    // Drain outstanding results
    rdy_mode = 2;
    begin
      int t;
      t = 0;
      while (sb.size() != 0 && t < 1000) begin
        @(posedge clk);
        t++;
      end
      if (sb.size() != 0) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
